// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types, state codes and helpers for the sequential multiplier
package mul_pkg;

  typedef logic [1:0] mul_state_t;

  localparam mul_state_t ST_IDLE = 2'd0;
  localparam mul_state_t ST_BUSY = 2'd1;
  localparam mul_state_t ST_FIX  = 2'd2;
  localparam mul_state_t ST_DONE = 2'd3;

  localparam int STEP_1 = 1;
  localparam int STEP_2 = 2;
  localparam int STEP_4 = 4;

  // Accept-to-result latency in cycles: the BUSY iterations plus the FIX cycle.
  function automatic int MUL_LAT(input int width, input int step);
    return width / step + 1;
  endfunction

  function automatic bit step_legal(input int step);
    return (step == STEP_1) || (step == STEP_2) || (step == STEP_4);
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - operand/result handshake bundle; sgn exists only with MUL_SIGNED_EN
interface mul_seq_if #(
  parameter int WIDTH = 32
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
`ifdef MUL_SIGNED_EN
  logic               sgn;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] res;

`ifdef MUL_SIGNED_EN
  modport master (
    output in_valid, op1, op2, sgn, out_ready,
    input  in_ready, out_valid, res
  );

  modport slave (
    input  in_valid, op1, op2, sgn, out_ready,
    output in_ready, out_valid, res
  );
`else
  modport master (
    output in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, res
  );

  modport slave (
    input  in_valid, op1, op2, out_ready,
    output in_ready, out_valid, res
  );
`endif

endinterface

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one combinational shift-add iteration retiring STEP multiplier bits
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = STEP_2
) (
  input  logic [WIDTH-1:0]      mcand_i,
  input  logic [WIDTH+STEP-1:0] acc_i,
  input  logic [WIDTH-1:0]      mplier_i,
  output logic [WIDTH+STEP-1:0] acc_o,
  output logic [WIDTH-1:0]      mplier_o
);

  localparam int AW = WIDTH + STEP;

  logic [AW-1:0] partial;
  logic [AW-1:0] sum;

  // acc stays below 2^WIDTH between iterations, so the sum cannot overflow AW bits.
  assign partial = {{STEP{1'b0}}, mcand_i} * {{WIDTH{1'b0}}, mplier_i[STEP-1:0]};
  assign sum     = acc_i + partial;
  assign acc_o   = {{STEP{1'b0}}, sum[AW-1:STEP]};

  if (STEP == WIDTH) begin : g_full
    assign mplier_o = sum[STEP-1:0];
  end else begin : g_shift
    assign mplier_o = {sum[STEP-1:0], mplier_i[WIDTH-1:STEP]};
  end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - WIDTH/STEP-cycle sequential multiplier with valid/ready handshakes
// Signed operands are supported when MUL_SIGNED_EN is defined; otherwise unsigned only.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = STEP_2
) (
  input  logic     clk,
  input  logic     rst_n,
  mul_seq_if.slave bus
);

  localparam int N  = MUL_LAT(WIDTH, STEP) - 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = WIDTH + STEP;

  if (!step_legal(STEP) || (WIDTH % STEP) != 0 || WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_cfg
    $error("mul_seq: illegal WIDTH/STEP combination");
  end

  mul_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic [AW-1:0]      step_acc;
  logic [WIDTH-1:0]   step_mplier;
  logic [2*WIDTH-1:0] prod;

  assign prod = {acc_q[WIDTH-1:0], mplier_q};

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitudes are unsigned WIDTH-bit values, so negating the most-negative input is exact.
  assign op1_mag = (bus.sgn && bus.op1[WIDTH-1]) ? -bus.op1 : bus.op1;
  assign op2_mag = (bus.sgn && bus.op2[WIDTH-1]) ? -bus.op2 : bus.op2;

  always_comb begin
    neg_d = neg_q;
    if (state_q == ST_IDLE && bus.in_valid) begin
      neg_d = bus.sgn & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`else
  assign op1_mag = bus.op1;
  assign op2_mag = bus.op2;
`endif

  mul_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .mcand_i  (mcand_q),
    .acc_i    (acc_q),
    .mplier_i (mplier_q),
    .acc_o    (step_acc),
    .mplier_o (step_mplier)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    res_d    = res_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = op1_mag;
          mplier_d = op2_mag;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d    = step_acc;
        mplier_d = step_mplier;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIX: begin
`ifdef MUL_SIGNED_EN
        res_d = neg_q ? -prod : prod;
`else
        res_d = prod;
`endif
        state_d = ST_DONE;
      end
      default: begin
        // Input requests seen here are deliberately dropped; a new accept needs IDLE.
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.res       = res_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - randomized and directed checks of mul_seq for STEP 1, 2 and 4 (MUL_SIGNED_EN aware)
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef MUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  int step_of [3] = '{1, 2, 4};
  int checks = 0;
  int errors = 0;

  logic        in_valid_t  [3];
  logic        out_ready_t [3];
  logic [31:0] op1_t       [3];
  logic [31:0] op2_t       [3];
  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [63:0] res_w       [3];
`ifdef MUL_SIGNED_EN
  logic        sgn_t       [3];
`endif

  mul_seq_if #(.WIDTH(32)) u_if1 ();
  mul_seq_if #(.WIDTH(32)) u_if2 ();
  mul_seq_if #(.WIDTH(32)) u_if4 ();

  mul_seq #(.WIDTH(32), .STEP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));
  mul_seq #(.WIDTH(32), .STEP(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2));
  mul_seq #(.WIDTH(32), .STEP(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(u_if4));

  assign u_if1.in_valid  = in_valid_t[0];
  assign u_if1.out_ready = out_ready_t[0];
  assign u_if1.op1       = op1_t[0];
  assign u_if1.op2       = op2_t[0];
  assign in_ready_w[0]   = u_if1.in_ready;
  assign out_valid_w[0]  = u_if1.out_valid;
  assign res_w[0]        = u_if1.res;

  assign u_if2.in_valid  = in_valid_t[1];
  assign u_if2.out_ready = out_ready_t[1];
  assign u_if2.op1       = op1_t[1];
  assign u_if2.op2       = op2_t[1];
  assign in_ready_w[1]   = u_if2.in_ready;
  assign out_valid_w[1]  = u_if2.out_valid;
  assign res_w[1]        = u_if2.res;

  assign u_if4.in_valid  = in_valid_t[2];
  assign u_if4.out_ready = out_ready_t[2];
  assign u_if4.op1       = op1_t[2];
  assign u_if4.op2       = op2_t[2];
  assign in_ready_w[2]   = u_if4.in_ready;
  assign out_valid_w[2]  = u_if4.out_valid;
  assign res_w[2]        = u_if4.res;

`ifdef MUL_SIGNED_EN
  assign u_if1.sgn = sgn_t[0];
  assign u_if2.sgn = sgn_t[1];
  assign u_if4.sgn = sgn_t[2];
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit hold_out);
    int n = 0;
    while (!in_ready_w[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_ready_k%0d", k), in_ready_w[k], 1'b1);
    op1_t[k]       = a;
    op2_t[k]       = b;
`ifdef MUL_SIGNED_EN
    sgn_t[k]       = s;
`else
    if (s) op1_t[k] = a;
`endif
    in_valid_t[k]  = 1'b1;
    out_ready_t[k] = !hold_out;
    @(posedge clk);
    @(negedge clk);
    in_valid_t[k] = 1'b0;
    op1_t[k]      = $urandom;
    op2_t[k]      = $urandom;
    chk($sformatf("busy_in_ready_k%0d", k), in_ready_w[k], 1'b0);
  endtask

  task automatic wait_done(input int k, input logic [63:0] exp, input string tag);
    int cyc = 0;
    while (!out_valid_w[k] && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("%s_lat_k%0d", tag, k), 64'(cyc), 64'(32 / step_of[k] + 1));
    chk($sformatf("%s_res_k%0d", tag, k), res_w[k], exp);
  endtask

  task automatic hold_and_finish(input int k, input int hold, input logic [63:0] exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold_res_k%0d", k), res_w[k], exp);
      chk($sformatf("hold_valid_k%0d", k), out_valid_w[k], 1'b1);
    end
    out_ready_t[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("ret_valid_k%0d", k), out_valid_w[k], 1'b0);
    chk($sformatf("ret_ready_k%0d", k), in_ready_w[k], 1'b1);
  endtask

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int hold, input string tag);
    logic [63:0] exp;
    exp = ref_mul(a, b, s);
    start_op(k, a, b, s, hold != 0);
    wait_done(k, exp, tag);
    hold_and_finish(k, hold, exp);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          h;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_t[k]  = 1'b0;
      out_ready_t[k] = 1'b1;
      op1_t[k]       = '0;
      op2_t[k]       = '0;
`ifdef MUL_SIGNED_EN
      sgn_t[k]       = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready_k%0d", k), in_ready_w[k], 1'b1);
      chk($sformatf("rst_out_valid_k%0d", k), out_valid_w[k], 1'b0);
      chk($sformatf("rst_res_k%0d", k), res_w[k], 64'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      run_op(k, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, "maxu");
      chk($sformatf("maxu_const_k%0d", k), res_w[k], 64'hFFFFFFFE00000001);
    end
    run_op(1, 32'h9, 32'h7, 1'b0, 0, "nine_seven");
    chk("nine_seven_const", res_w[1], 64'h3F);
    run_op(1, 32'h0, 32'hDEADBEEF, 1'b0, 0, "zero");

`ifdef MUL_SIGNED_EN
    for (int k = 0; k < 3; k++) begin
      run_op(k, 32'hFFFFFFFF, 32'h7, 1'b1, 0, "s_m1x7");
      chk($sformatf("s_m1x7_const_k%0d", k), res_w[k], 64'hFFFFFFFFFFFFFFF9);
      run_op(k, 32'h80000000, 32'h80000000, 1'b1, 0, "s_minsq");
      chk($sformatf("s_minsq_const_k%0d", k), res_w[k], 64'h4000000000000000);
    end
`endif

    // Backpressure: result held while new operands are presented in DONE.
    start_op(1, 32'h9, 32'h7, 1'b0, 1'b1);
    wait_done(1, 64'h3F, "bp");
    for (int i = 0; i < 5; i++) begin
      op1_t[1]      = 32'h3;
      op2_t[1]      = 32'h5;
      in_valid_t[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_res", res_w[1], 64'h3F);
      chk("bp_in_ready", in_ready_w[1], 1'b0);
      chk("bp_out_valid", out_valid_w[1], 1'b1);
    end
    out_ready_t[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ret_ready", in_ready_w[1], 1'b1);
    chk("bp_ret_valid", out_valid_w[1], 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid_t[1] = 1'b0;
    chk("bp_accept", in_ready_w[1], 1'b0);
    wait_done(1, 64'hF, "bp_next");
    hold_and_finish(1, 0, 64'hF);

    // Asynchronous reset in the middle of BUSY.
    run_op(1, 32'h1234, 32'h10, 1'b0, 0, "pre_rst");
    start_op(1, 32'h3, 32'h5, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid_w[1], 1'b0);
    chk("mid_rst_res", res_w[1], 64'h0);
    chk("mid_rst_in_ready", in_ready_w[1], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", out_valid_w[1], 1'b0);
    run_op(1, 32'h3, 32'h5, 1'b0, 0, "post_rst");
    chk("post_rst_const", res_w[1], 64'hF);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 12; i++) begin
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 3) == 0) a = 32'h80000000;
        if ($urandom_range(0, 3) == 0) b = 32'hFFFFFFFF;
        s = 1'($urandom_range(0, 1));
        h = $urandom_range(0, 3);
        run_op(k, a, b, s, h, "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Parametrised sequential multiplier, successor to the combinational 32-bit multiplier. It computes a full-width 2·WIDTH-bit product of two WIDTH-bit operands over WIDTH/STEP clock cycles, retiring STEP multiplier bits per cycle, with optional signed mode. Valid/ready handshakes on input and output let it sit directly in an ALU or datapath pipeline, trading latency for area.

## Interface
- WIDTH, 32: operand width; even, ≥ 4.
- STEP, 2: multiplier bits retired per cycle; one of 1, 2, 4; must divide WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  op1/op2/sgn valid.
- in_ready  out  1  block can accept operands.
- op1  in  WIDTH  multiplicand.
- op2  in  WIDTH  multiplier.
- sgn  in  1  1 = two's-complement operands, 0 = unsigned. Only present when MUL_SIGNED_EN is defined.
- out_valid  out  1  res holds a completed product.
- out_ready  in  1  consumer accepts res.
- res  out  2·WIDTH  product.

## Operation
- States:
  - IDLE: in_ready=1. An input handshake (in_valid & in_ready) captures the operands and moves to BUSY.
  - BUSY: runs exactly N = WIDTH/STEP iterations, then moves to FIX.
  - FIX: one cycle; writes res and moves to DONE.
  - DONE: out_valid=1. An output handshake (out_valid & out_ready) moves to IDLE.
- Capture:
  - mcand = |op1|, mplier = |op2|. The absolute value applies only when sgn=1; otherwise the operand is taken as is.
  - neg = sgn & (op1[MSB] ^ op2[MSB]).
  - Magnitudes are WIDTH-bit unsigned, so the most-negative input is represented exactly.
- Iteration: {acc, mplier} ← ({acc, mplier} + ((mcand · mplier[STEP-1:0]) << WIDTH)) >> STEP.
  - acc is WIDTH+STEP bits wide internally; no overflow is possible.
  - An iteration counter counts 0..N-1.
- FIX: res ← neg ? −{acc, mplier} : {acc, mplier}, truncated to 2·WIDTH bits.
- in_ready is 0 in BUSY, FIX and DONE. Inputs arriving then are ignored; no operand register changes.
- res and out_valid hold stable in DONE until out_ready is sampled high.
- Zero operands still take the full latency; there is no early termination.
- res keeps the last product after return to IDLE; it is valid only while out_valid=1.

## Timing
- Reset (asynchronous, any state):
  - state = IDLE, in_ready = 1, out_valid = 0, res = 0.
  - Counter and all internal registers clear.
  - Any in-flight operation is dropped with no output.
- Latency: the accept edge is edge 0; out_valid rises after edge N+1 (BUSY N cycles + FIX 1).
  - WIDTH=32: STEP=1 → 33 cycles, STEP=2 → 17, STEP=4 → 9.
- Throughput: one operation per N+3 cycles when out_ready is tied high. The handshake edge in DONE returns to IDLE, and the next accept happens at the following edge at the earliest.
- Simultaneous in_valid with an out handshake in DONE: the input is not accepted that cycle.
- in_ready and out_valid are pure state decodes: registered, with no combinational path from in_valid or out_ready.

## Configuration
- MUL_SIGNED_EN defined:
  - The sgn port exists.
  - Capture takes absolute values and FIX applies conditional negation as described above.
- MUL_SIGNED_EN undefined:
  - No sgn port; neg is constant 0 and the abs/negate logic is removed.
  - The block is unsigned only.
  - The FIX state remains, so latency is identical in both builds.

## Structure
- Shared package mul_pkg:
  - state typedef (IDLE, BUSY, FIX, DONE).
  - MUL_LAT function returning WIDTH/STEP + 1.
  - Legal STEP constants.
- Sub-module mul_step: combinational single iteration.
  - Inputs: mcand, acc, mplier slice.
  - Output: next {acc, mplier}.
  - Parametrised by WIDTH and STEP and instantiated once.
- Top level holds the FSM, counter, operand registers and result register.

## Test plan
- Unsigned 32'h9 × 32'h7, STEP=2 → res = 64'h3F; out_valid rises 17 cycles after accept.
- Unsigned 32'hFFFFFFFF × 32'hFFFFFFFF, for each STEP ∈ {1,2,4} → res = 64'hFFFFFFFE00000001; latency 33/17/9 cycles.
- Signed (MUL_SIGNED_EN), sgn=1:
  - 32'hFFFFFFFF × 32'h7 → res = 64'hFFFFFFFFFFFFFFF9.
  - 32'h80000000 × 32'h80000000 → res = 64'h4000000000000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, and drive new in_valid with different operands meanwhile.
  - Required: res stays 64'h3F, in_ready=0 throughout.
  - The new operands are accepted only after return to IDLE.
- Reset mid-operation: assert rst_n=0 at BUSY iteration 5.
  - Required: immediately out_valid=0, res=0, in_ready=1.
  - After release, a fresh 3×5 operation yields res = 64'hF.
